// File: rtl/shift_ser_pkg.sv
// Shared types and default sizes for the serial shift controller slice.
//   state_t    : controller FSM states, 2-bit encoding
//   WIDTH_DEF  : default word width (must match the driven shift register)
//   DIV_W_DEF  : default width of the bit-period configuration
package shift_ser_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/shift_tick_div.sv
// Bit-period down-counter.
//   clk        : clock, rising edge
//   resetn     : synchronous active-low reset, clears the count
//   reload     : load reload_val (takes priority over counting)
//   reload_val : period minus 1, in cycles
//   en         : decrement while nonzero
//   zero       : count is currently zero (current bit period ends this cycle)
module shift_tick_div #(
  parameter int DIV_W = shift_ser_pkg::DIV_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             reload,
  input  logic [DIV_W-1:0] reload_val,
  input  logic             en,
  output logic             zero
);

  logic [DIV_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= reload_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/shift_ser_ctrl.sv
// Sequencing controller for a load/enable right-shift register.
// Accepts one word per valid/ready handshake, loads it into the register,
// then holds each bit on q[0] for (div_q+1) cycles, pulsing sr_ena between
// bits. No shift is issued after the last bit.
//   clk, resetn          : clock and synchronous active-low reset
//   in_valid/in_ready    : word handshake; in_data bit 0 goes out first
//   cfg_div              : bit period minus 1, captured at accept
//   abort                : cancel the current word (blocks accept in IDLE)
//   sr_load/sr_ena/sr_data : drive the shift register
//   bit_valid, bit_idx   : q[0] holds a live bit, and which one
//   done                 : one-cycle pulse after the last bit period
module shift_ser_ctrl
  import shift_ser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             abort,
  output logic             sr_load,
  output logic             sr_ena,
  output logic [WIDTH-1:0] sr_data,
  output logic             bit_valid,
  output logic [IDX_W-1:0] bit_idx,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] bit_cnt;

  logic div_zero;
  logic last_bit;
  logic bit_end;
  logic accept;
  logic div_reload;
  logic div_en;

  assign last_bit = (bit_cnt == IDX_W'(WIDTH - 1));
  assign bit_end  = (state == HOLD) && div_zero;
  assign accept   = in_valid && in_ready;

  // Period restarts on entry to HOLD and at every intermediate bit boundary;
  // an abort leaves the counter alone since HOLD is being abandoned anyway.
  assign div_reload = !abort && ((state == LOAD) || (bit_end && !last_bit));
  assign div_en     = !abort && (state == HOLD);

  shift_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk        (clk),
    .resetn     (resetn),
    .reload     (div_reload),
    .reload_val (div_q),
    .en         (div_en),
    .zero       (div_zero)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      data_q  <= '0;
      div_q   <= '0;
      bit_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            data_q <= in_data;
            div_q  <= cfg_div;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            bit_cnt <= '0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (abort) begin
            state <= IDLE;
          end else if (div_zero) begin
            if (last_bit) state <= DONE;
            else          bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state. resetn also forces them to zero so the
  // register sees no load/enable while reset is held, even mid-word.
  assign in_ready  = resetn && (state == IDLE) && !abort;
  assign sr_load   = resetn && (state == LOAD);
  assign sr_ena    = resetn && bit_end && !last_bit;
  assign sr_data   = resetn ? data_q : '0;
  assign bit_valid = resetn && (state == HOLD);
  assign bit_idx   = bit_valid ? bit_cnt : '0;
  assign done      = resetn && (state == DONE);

endmodule

// File: tb/tb_shift_ser_ctrl.sv
// Self-checking bench for shift_ser_ctrl. A per-word schedule of expected
// output beats is built at accept time from the word and its divider; the
// serial bit is observed through a shift register driven by the DUT's sr_*.
module tb_shift_ser_ctrl;
  import shift_ser_pkg::*;

  localparam int WIDTH = 4;
  localparam int DIV_W = 8;
  localparam int IDX_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [DIV_W-1:0] cfg_div;
  logic             abort;
  logic             sr_load;
  logic             sr_ena;
  logic [WIDTH-1:0] sr_data;
  logic             bit_valid;
  logic [IDX_W-1:0] bit_idx;
  logic             done;

  always #5 clk = ~clk;

  shift_ser_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cfg_div   (cfg_div),
    .abort     (abort),
    .sr_load   (sr_load),
    .sr_ena    (sr_ena),
    .sr_data   (sr_data),
    .bit_valid (bit_valid),
    .bit_idx   (bit_idx),
    .done      (done)
  );

  // One expected cycle of controller output.
  typedef struct packed {
    logic             load;
    logic             ena;
    logic             bv;
    logic             dn;
    logic [IDX_W-1:0] idx;
  } beat_t;

  beat_t            sched[$];
  logic [WIDTH-1:0] word_m;   // last accepted word (what sr_data shows)
  logic [WIDTH-1:0] sreg;     // the shift register (areset tied low)
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
    else n_pass++;
  endtask

  // LOAD beat, WIDTH*(d+1) hold beats (shift at the end of every bit but
  // the last), then the DONE beat.
  task automatic push_word(input logic [DIV_W-1:0] d);
    beat_t b;
    b = '0; b.load = 1'b1;
    sched.push_back(b);
    for (int i = 0; i < WIDTH; i++) begin
      for (int k = 0; k <= int'(d); k++) begin
        b = '0;
        b.bv  = 1'b1;
        b.idx = IDX_W'(i);
        b.ena = (k == int'(d)) && (i < WIDTH - 1);
        sched.push_back(b);
      end
    end
    b = '0; b.dn = 1'b1;
    sched.push_back(b);
  endtask

  // Drive one cycle, check at the falling edge, advance the model at the
  // rising edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] dat,
                      input logic [DIV_W-1:0] div, input logic ab, input logic rn);
    beat_t            e;
    logic             rdy_e;
    logic             ld, en;
    logic [WIDTH-1:0] sd;
    in_valid = v; in_data = dat; cfg_div = div; abort = ab; resetn = rn;
    @(negedge clk);
    e = '0;
    rdy_e = 1'b0;
    if (rn) begin
      if (sched.size() == 0) rdy_e = !ab;
      else e = sched[0];
    end
    check("in_ready",  in_ready,  rdy_e);
    check("sr_load",   sr_load,   e.load);
    check("sr_ena",    sr_ena,    e.ena);
    check("bit_valid", bit_valid, e.bv);
    check("bit_idx",   bit_idx,   e.idx);
    check("done",      done,      e.dn);
    check("sr_data",   sr_data,   rn ? word_m : '0);
    if (rn && e.bv) check("q0", sreg[0], word_m[e.idx]);
    ld = sr_load; en = sr_ena; sd = sr_data;
    @(posedge clk);
    if (ld)      sreg = sd;
    else if (en) sreg = sreg >> 1;
    if (!rn) begin
      sched.delete();
      word_m = '0;
    end else if (sched.size() != 0) begin
      if (ab) sched.delete();
      else void'(sched.pop_front());
    end else if (v && rdy_e) begin
      word_m = dat;
      push_word(div);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    word_m = '0;
    sreg   = '0;
    resetn = 1'b0; in_valid = 1'b1; in_data = 4'hA; cfg_div = '0; abort = 1'b0;
    @(posedge clk); #1;

    // Reset held with in_valid=1, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 4'hA, 8'd0, 1'b0, 1'b0);
    idle(1);

    // Basic word, one cycle per bit.
    step(1'b1, 4'b1011, 8'd0, 1'b0, 1'b1);
    idle(8);

    // Divider 2; cfg_div drops to 0 at cycle 3 and must be ignored.
    step(1'b1, 4'b0110, 8'd2, 1'b0, 1'b1);
    for (int c = 1; c < 17; c++) step(1'b0, '0, (c < 3) ? 8'd2 : 8'd0, 1'b0, 1'b1);

    // Abort while bit 2 is held (divider 1: bit 2 starts at cycle 6).
    step(1'b1, 4'b1101, 8'd1, 1'b0, 1'b1);
    for (int c = 1; c < 12; c++) step(1'b0, '0, 8'd1, c == 6, 1'b1);

    // Busy hold-off: a second word offered continuously.
    step(1'b1, 4'b1001, 8'd0, 1'b0, 1'b1);
    for (int c = 1; c < 16; c++) step(1'b1, 4'b0111, 8'd0, 1'b0, 1'b1);
    idle(2);

    // Reset during LOAD.
    step(1'b1, 4'b1111, 8'd1, 1'b0, 1'b1);
    step(1'b0, '0, 8'd1, 1'b0, 1'b0);
    idle(4);

    // Abort in IDLE blocks acceptance.
    step(1'b1, 4'b0101, 8'd0, 1'b1, 1'b1);
    idle(2);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 9) < 7,
           WIDTH'($urandom),
           DIV_W'($urandom_range(0, 3)),
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 99) != 0);
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
